// File: rtl/key_led_pkg.sv
// Shared mode codes for the key-driven LED sequencer.
// Codes 5..7 are never produced and decode as IDLE.
package key_led_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_IDLE  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_UP    = 3'd1;
    localparam logic [MODE_W-1:0] MODE_DOWN  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_BLINK = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ON    = 3'd4;

    // Key k selects mode k+1.
    function automatic logic [MODE_W-1:0] key_to_mode(input int idx);
        return MODE_W'(idx + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-FF synchroniser, stability debouncer and a one-cycle
// pulse on each debounced press (1 -> 0). Release produces no pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_db,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             db_prev;
    logic [CNT_W-1:0] cnt;

    // NOTE: every register here, synchroniser included, resets to the idle
    // (released) level so nothing looks like a press out of reset, and all
    // state is updated with <= so the flops see each other's old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1  <= 1'b1;
            sync_2  <= 1'b1;
            key_db  <= 1'b1;
            db_prev <= 1'b1;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_1  <= key_raw;
            sync_2  <= sync_1;
            db_prev <= key_db;
            press   <= db_prev & ~key_db;

            // Any cycle agreeing with the accepted level restarts the count.
            if (sync_2 == key_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                key_db <= sync_2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_led_seq.sv
// Four debounced keys select a display mode; a step timer walks or blinks
// a pattern across N_LED outputs. Each mode change restarts the pattern.
module key_led_seq
    import key_led_pkg::*;
#(
    parameter int N_LED           = 4,
    parameter int STEP_CYCLES     = 10_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        key,
    output logic [N_LED-1:0]  led,
    output logic [MODE_W-1:0] mode
);

    localparam int STEP_W = $clog2(STEP_CYCLES);
    localparam int POS_W  = $clog2(N_LED);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(N_LED - 1);
    localparam logic [N_LED-1:0]  LED_ONE   = N_LED'(1);

    logic [3:0]        press;
    logic [3:0]        key_db_unused;
    logic              hit;
    logic [MODE_W-1:0] target;
    logic [STEP_W-1:0] step_cnt;
    logic [POS_W-1:0]  pos;
    logic              phase;
    logic [N_LED-1:0]  led_next;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .key_raw(key[i]),
            .key_db (key_db_unused[i]),
            .press  (press[i])
        );
    end

    // NOTE: hit and target get defaults before the loop so no path leaves
    // them unassigned; without that the tool would infer latches.
    always_comb begin
        hit    = 1'b0;
        target = MODE_IDLE;
        // Descending scan so the lowest pulsing key is the last one written.
        for (int i = 3; i >= 0; i--) begin
            if (press[i]) begin
                hit    = 1'b1;
                target = key_to_mode(i);
            end
        end
    end

    always_comb begin
        led_next = '0;
        case (mode)
            MODE_UP:    led_next = LED_ONE << pos;
            MODE_DOWN:  led_next = LED_ONE << (POS_LAST - pos);
            MODE_BLINK: led_next = phase ? '0 : '1;
            MODE_ON:    led_next = '1;
            default:    led_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode     <= MODE_IDLE;
            step_cnt <= '0;
            pos      <= '0;
            phase    <= 1'b0;
            led      <= '0;
        end else begin
            led <= led_next;
            if (hit) begin
                // Pressing the key of the active mode toggles back to IDLE.
                mode     <= (target == mode) ? MODE_IDLE : target;
                step_cnt <= '0;
                pos      <= '0;
                phase    <= 1'b0;
            end else if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                pos      <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
                phase    <= ~phase;
            end else begin
                step_cnt <= step_cnt + STEP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_key_led_seq.sv
// Bench for key_led_seq: 4- and 6-LED instances share keys, checked every
// cycle against a sample-history / frame-arithmetic model of the block.
module tb_key_led_seq;

    localparam int STEP = 8;
    localparam int DEB  = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] key;
    logic [3:0] led4;
    logic [5:0] led6;
    logic [2:0] mode4;
    logic [2:0] mode6;

    int n_checks = 0;
    int n_fail   = 0;

    key_led_seq #(.N_LED(4), .STEP_CYCLES(STEP), .DEBOUNCE_CYCLES(DEB)) dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .key  (key),
        .led  (led4),
        .mode (mode4)
    );

    key_led_seq #(.N_LED(6), .STEP_CYCLES(STEP), .DEBOUNCE_CYCLES(DEB)) dut6 (
        .clk  (clk),
        .rst_n(rst_n),
        .key  (key),
        .led  (led6),
        .mode (mode6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    // Edge n (1 = first posedge after reset) samples key. A key's accepted
    // level flips at edge n when raw samples n-1-DEB .. n-2 all differ from
    // it. A fall at edge n changes mode at edge n+2. The frame shown after
    // edge n is floor((n-1-last_change)/STEP) for the mode held after n-1.
    function automatic logic [31:0] model_led(input int m, input int f, input int n);
        logic [31:0] all_on;
        all_on = (32'd1 << n) - 32'd1;
        case (m)
            1:       return 32'd1 << (f % n);
            2:       return 32'd1 << (n - 1 - (f % n));
            3:       return ((f % 2) == 0) ? all_on : 32'd0;
            4:       return all_on;
            default: return 32'd0;
        endcase
    endfunction

    int          cyc;
    int          m_mode;
    int          last_change;
    logic [3:0]  db;
    logic [3:0]  hist[$];
    int          ev_edge[$];
    int          ev_key[$];
    logic [31:0] exp_led4 = '0;
    logic [31:0] exp_led6 = '0;
    logic [31:0] exp_mode = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc         = 0;
            m_mode      = 0;
            last_change = 0;
            db          = 4'hF;
            hist.delete();
            repeat (DEB + 1) hist.push_back(4'hF);
            ev_edge.delete();
            ev_key.delete();
            exp_led4    = '0;
            exp_led6    = '0;
            exp_mode    = '0;
        end else begin
            int f;
            logic [3:0] fell;
            cyc++;
            f = (cyc - 1 - last_change) / STEP;
            exp_led4 = model_led(m_mode, f, 4);
            exp_led6 = model_led(m_mode, f, 6);
            if (ev_edge.size() > 0 && ev_edge[0] == cyc) begin
                int k;
                k = ev_key.pop_front();
                void'(ev_edge.pop_front());
                m_mode      = (m_mode == k + 1) ? 0 : k + 1;
                last_change = cyc;
            end
            exp_mode = 32'(m_mode);

            hist.push_back(key);
            if (hist.size() > DEB + 2) void'(hist.pop_front());
            fell = '0;
            for (int k = 0; k < 4; k++) begin
                bit stable;
                stable = 1'b1;
                for (int i = 0; i < DEB; i++)
                    if (hist[i][k] == db[k]) stable = 1'b0;
                if (stable) begin
                    db[k] = ~db[k];
                    if (!db[k]) fell[k] = 1'b1;
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (fell[k]) begin
                    ev_edge.push_back(cyc + 2);
                    ev_key.push_back(k);
                    break;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("led4", 32'(led4), exp_led4);
            check("led6", 32'(led6), exp_led6);
            check("mode4", 32'(mode4), exp_mode);
            check("mode6", 32'(mode6), exp_mode);
        end
    end

    // Press mask at a negedge, hold 10 cycles; checks mode after edge 8,
    // first frame after edge 9, second frame after edge 17.
    task automatic press_check(input logic [3:0] mask, input logic [2:0] m,
                               input logic [3:0] frame0, input logic [3:0] frame1);
        key = key & ~mask;
        tick(8);
        check("press_mode", 32'(mode4), 32'(m));
        tick(1);
        check("press_frame0", 32'(led4), 32'(frame0));
        tick(1);
        key = key | mask;
        tick(7);
        check("press_frame1", 32'(led4), 32'(frame1));
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 4'hF;
        tick(3);
        check("reset_led4", 32'(led4), 32'h0);
        check("reset_led6", 32'(led6), 32'h0);
        check("reset_mode", 32'(mode4), 32'h0);
        rst_n = 1'b1;

        tick(3 * STEP);
        check("idle_mode", 32'(mode4), 32'h0);
        check("idle_led", 32'(led4), 32'h0);

        for (int w = 1; w <= 3; w++) begin
            key[0] = 1'b0;
            tick(w);
            key[0] = 1'b1;
            tick(10);
        end
        check("bounce_mode", 32'(mode4), 32'h0);

        press_check(4'b0001, 3'd1, 4'b0001, 4'b0010);
        tick(8);  check("up_f2", 32'(led4), 32'h4);
        tick(8);  check("up_f3", 32'(led4), 32'h8);
        tick(8);  check("up_f4_wrap", 32'(led4), 32'h1);
        tick(8);  check("up6_bit5", 32'(led6), 32'h20);
        tick(8);  check("up6_wrap", 32'(led6), 32'h01);
        tick(4);

        press_check(4'b0001, 3'd0, 4'b0000, 4'b0000);
        tick(4);
        press_check(4'b0010, 3'd2, 4'b1000, 4'b0100);
        tick(4);
        press_check(4'b1100, 3'd3, 4'b1111, 4'b0000);
        tick(8);  check("blink_f2", 32'(led4), 32'hF);
        tick(4);
        press_check(4'b1000, 3'd4, 4'b1111, 4'b1111);
        tick(8);  check("on_steady", 32'(led4), 32'hF);
        tick(4);
        press_check(4'b0100, 3'd3, 4'b1111, 4'b0000);
        tick(3);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led4", 32'(led4), 32'h0);
        check("async_rst_led6", 32'(led6), 32'h0);
        check("async_rst_mode", 32'(mode4), 32'h0);
        #3 rst_n = 1'b1;
        tick(30);
        check("post_rst_mode", 32'(mode4), 32'h0);
        check("post_rst_led", 32'(led4), 32'h0);

        for (int it = 0; it < 80; it++) begin
            logic [3:0] mask;
            mask = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) != 0) mask = 4'b0001 << $urandom_range(0, 3);
            key = key & ~mask;
            tick($urandom_range(1, 12));
            key = 4'hF;
            tick($urandom_range(1, 24));
        end
        tick(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
